// File: rtl/irq_capture.sv
// Interrupt capture: edge-detects irq_in into pending, masks into req_vec, tracks overflow.
// Optional macro IRQ_SYNC_EN adds a synchronizer stage for asynchronous irq_in.
module irq_capture #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   irq_mask,
  input  logic           ack,
  input  logic [IDW-1:0] ack_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   req_vec,
  output logic           irq_valid,
  output logic [N-1:0]   ovf,
  output logic           ack_err
);

  logic [N-1:0] s0;
  logic [N-1:0] s_prev;
  logic [N-1:0] s0_src;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] ovf_nxt;
  logic [N-1:0] req_nxt;
  logic         ack_hit;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sy1;

  // s0 doubles as the second synchronizer flop, giving a 3-edge input-to-pending latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sy1 <= '0;
    end else begin
      sy1 <= irq_in;
    end
  end

  assign s0_src = sy1;
`else
  assign s0_src = irq_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0     <= '0;
      s_prev <= '0;
    end else begin
      s0     <= s0_src;
      s_prev <= s0;
    end
  end

  always_comb begin
    rise = s0 & ~s_prev;
    clr  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      clr[i] = ack && (ack_id == IDW'(i));
    end
    // An out-of-range ack_id matches no bit, so it falls out as an error with no clear.
    ack_hit     = |(clr & pending);
    pending_nxt = (pending & ~clr) | rise;
    // A rise coinciding with its own ack is a fresh event, not an overflow.
    ovf_nxt     = (ovf & ~clr) | (rise & pending & ~clr);
    req_nxt     = pending_nxt & ~irq_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      req_vec   <= '0;
      irq_valid <= 1'b0;
      ovf       <= '0;
      ack_err   <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      req_vec   <= req_nxt;
      irq_valid <= |req_nxt;
      ovf       <= ovf_nxt;
      ack_err   <= ack & ~ack_hit;
    end
  end

endmodule
